// File: rtl/demux4_buf_if.sv
// Bundle of the demux4_buf streams: one tagged input stream and four
// destination streams, each with val/rdy handshaking.
interface demux4_buf_if #(
    parameter int p_nbits = 1
);
    logic               in_val;
    logic               in_rdy;
    logic [1:0]         in_sel;
    logic [p_nbits-1:0] in_msg;

    logic               out0_val;
    logic               out0_rdy;
    logic [p_nbits-1:0] out0_msg;
    logic               out1_val;
    logic               out1_rdy;
    logic [p_nbits-1:0] out1_msg;
    logic               out2_val;
    logic               out2_rdy;
    logic [p_nbits-1:0] out2_msg;
    logic               out3_val;
    logic               out3_rdy;
    logic [p_nbits-1:0] out3_msg;

    // Producer and consumers side (drives the input stream, accepts outputs)
    modport master (
        output in_val, in_sel, in_msg,
        input  in_rdy,
        input  out0_val, out0_msg, out1_val, out1_msg,
        input  out2_val, out2_msg, out3_val, out3_msg,
        output out0_rdy, out1_rdy, out2_rdy, out3_rdy
    );

    // Demultiplexer side
    modport slave (
        input  in_val, in_sel, in_msg,
        output in_rdy,
        output out0_val, out0_msg, out1_val, out1_msg,
        output out2_val, out2_msg, out3_val, out3_msg,
        input  out0_rdy, out1_rdy, out2_rdy, out3_rdy
    );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 stream demultiplexer. Each destination owns a one-entry
// buffer so a stalled consumer only blocks traffic addressed to it.
// in_rdy is a combinational function of in_sel and the selected out_rdy.
module demux4_buf #(
    parameter int p_nbits = 1
) (
    input  logic          clk,
    input  logic          rst,
    demux4_buf_if.slave   bus
);

    logic [3:0]              full_q;
    logic [3:0]              full_d;
    logic [3:0][p_nbits-1:0] data_q;
    logic [3:0][p_nbits-1:0] data_d;

    logic [3:0]              out_rdy;
    logic                    in_rdy;
    logic                    in_xfer;
    logic [3:0]              out_xfer;

    // Gather per-destination ready, decide acceptance and next buffer state
    always_comb begin
        out_rdy  = {bus.out3_rdy, bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};
        in_rdy   = !rst && (!full_q[bus.in_sel] || out_rdy[bus.in_sel]);
        in_xfer  = bus.in_val && in_rdy;
        out_xfer = full_q & out_rdy;

        full_d = full_q & ~out_xfer;
        data_d = data_q;
        if (in_xfer) begin
            full_d[bus.in_sel] = 1'b1;
            data_d[bus.in_sel] = bus.in_msg;
        end
    end

    // Buffer registers; reset drops every held message and zeroes the data
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.out0_val = full_q[0];
    assign bus.out1_val = full_q[1];
    assign bus.out2_val = full_q[2];
    assign bus.out3_val = full_q[3];
    assign bus.out0_msg = data_q[0];
    assign bus.out1_msg = data_q[1];
    assign bus.out2_msg = data_q[2];
    assign bus.out3_msg = data_q[3];

endmodule

// File: tb/tb_demux4_buf.sv
// Bench for demux4_buf: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_demux4_buf;

    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux4_buf_if #(.p_nbits(NB)) bus ();

    demux4_buf #(.p_nbits(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: each destination is a FIFO of capacity one, plus the
    // last value written into it (what its msg port shows).
    logic [NB-1:0] mq [4][$];
    logic [NB-1:0] last_msg [4];
    int            delivered [4];

    // Sampled DUT outputs for the current cycle
    logic          s_in_rdy;
    logic [3:0]    s_val;
    logic [NB-1:0] s_msg [4];

    // Stability tracking: was destination stalled with data last cycle
    logic          stalled  [4];
    logic [NB-1:0] held_msg [4];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            mq[n].delete();
            last_msg[n] = '0;
            stalled[n]  = 1'b0;
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, check
    // against the model, then advance the model at the rising edge.
    task automatic do_cycle(input logic r, input logic v, input logic [1:0] s,
                            input logic [NB-1:0] m, input logic [3:0] rdy);
        logic exp_rdy;
        @(negedge clk);
        rst          = r;
        bus.in_val   = v;
        bus.in_sel   = s;
        bus.in_msg   = m;
        bus.out0_rdy = rdy[0];
        bus.out1_rdy = rdy[1];
        bus.out2_rdy = rdy[2];
        bus.out3_rdy = rdy[3];
        #1;
        s_in_rdy = bus.in_rdy;
        s_val    = {bus.out3_val, bus.out2_val, bus.out1_val, bus.out0_val};
        s_msg[0] = bus.out0_msg;
        s_msg[1] = bus.out1_msg;
        s_msg[2] = bus.out2_msg;
        s_msg[3] = bus.out3_msg;

        exp_rdy = !r && (mq[s].size() == 0 || rdy[s]);
        chk("model in_rdy", int'(s_in_rdy), int'(exp_rdy));
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("model out%0d_val", n), int'(s_val[n]), int'(mq[n].size() != 0));
            chk($sformatf("model out%0d_msg", n), int'(s_msg[n]), int'(last_msg[n]));
            if (stalled[n] && s_val[n])
                chk($sformatf("hold out%0d_msg", n), int'(s_msg[n]), int'(held_msg[n]));
        end

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int n = 0; n < 4; n++) begin
                stalled[n]  = s_val[n] && !rdy[n];
                held_msg[n] = s_msg[n];
                if (mq[n].size() != 0 && rdy[n]) begin
                    void'(mq[n].pop_front());
                    delivered[n]++;
                end
            end
            if (v && exp_rdy) begin
                mq[s].push_back(m);
                last_msg[s] = m;
            end
        end
    endtask

    typedef struct {
        logic                    v;
        logic [1:0]              sel;
        logic [NB-1:0]           msg;
        logic [3:0]              rdy;
        logic                    exp_in_rdy;
        logic [3:0]              exp_val;
        logic [3:0][NB-1:0]      exp_msg;   // index n = destination n
    } vec_t;

    vec_t vecs [13];

    initial begin
        bus.in_val = 1'b1; bus.in_sel = 2'd2; bus.in_msg = '0;
        bus.out0_rdy = 1'b1; bus.out1_rdy = 1'b1;
        bus.out2_rdy = 1'b1; bus.out3_rdy = 1'b1;
        model_reset();
        for (int n = 0; n < 4; n++) delivered[n] = 0;

        // Routing then back-pressure isolation; exp_msg is {out3,out2,out1,out0}
        vecs[0]  = '{1'b1, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1]  = '{1'b1, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hA0}};
        vecs[2]  = '{1'b1, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0010, {8'h00, 8'h00, 8'hA1, 8'hA0}};
        vecs[3]  = '{1'b1, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b0100, {8'h00, 8'hA2, 8'hA1, 8'hA0}};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b1000, {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
        vecs[6]  = '{1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0000, {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
        vecs[7]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, {8'hA3, 8'hA2, 8'h11, 8'hA0}};
        vecs[8]  = '{1'b1, 2'd3, 8'h33, 4'b1101, 1'b1, 4'b0010, {8'hA3, 8'hA2, 8'h11, 8'hA0}};
        vecs[9]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b1010, {8'h33, 8'hA2, 8'h11, 8'hA0}};
        vecs[10] = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, {8'h33, 8'hA2, 8'h11, 8'hA0}};
        vecs[11] = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0010, {8'h33, 8'hA2, 8'h22, 8'hA0}};
        vecs[12] = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, {8'h33, 8'hA2, 8'h22, 8'hA0}};

        // Reset held two cycles with a valid request to sel 2
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b1, 1'b1, 2'd2, 8'h5A, 4'b1111);
            chk("reset in_rdy", int'(s_in_rdy), 0);
            chk("reset vals", int'(s_val), 0);
        end
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 1'b0, 2'd2, 8'h00, 4'b1111);
            chk("post-reset vals", int'(s_val), 0);
            chk("post-reset msg2", int'(s_msg[2]), 0);
        end

        foreach (vecs[i]) begin
            do_cycle(1'b0, vecs[i].v, vecs[i].sel, vecs[i].msg, vecs[i].rdy);
            chk($sformatf("vec%0d in_rdy", i), int'(s_in_rdy), int'(vecs[i].exp_in_rdy));
            chk($sformatf("vec%0d vals", i), int'(s_val), int'(vecs[i].exp_val));
            for (int n = 0; n < 4; n++)
                chk($sformatf("vec%0d out%0d_msg", i, n), int'(s_msg[n]), int'(vecs[i].exp_msg[n]));
        end

        // Full throughput into destination 2
        for (int i = 0; i < 17; i++) begin
            do_cycle(1'b0, i < 16, 2'd2, 8'(i), 4'b1111);
            if (i < 16) chk("stream in_rdy", int'(s_in_rdy), 1);
            if (i > 0) begin
                chk("stream out2_val", int'(s_val[2]), 1);
                chk("stream out2_msg", int'(s_msg[2]), i - 1);
            end
        end

        // Reset mid-operation with out0 and out3 stalled full
        do_cycle(1'b0, 1'b1, 2'd0, 8'h5A, 4'b0000);
        do_cycle(1'b0, 1'b1, 2'd3, 8'hC3, 4'b0000);
        do_cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        chk("prefill vals", int'(s_val), 4'b1001);
        do_cycle(1'b1, 1'b1, 2'd1, 8'h77, 4'b0000);
        chk("midrst in_rdy", int'(s_in_rdy), 0);
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
            chk("after midrst vals", int'(s_val), 0);
            chk("after midrst msg0", int'(s_msg[0]), 0);
            chk("after midrst msg3", int'(s_msg[3]), 0);
        end

        // Randomized traffic, all checks via model and hold tracking
        void'($urandom(32'hC0FFEE));
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rdy;
            rdy    = 4'($urandom);
            rdy[2] = ($urandom_range(0, 2) == 0);
            do_cycle(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), rdy);
        end
        // Drain everything and confirm nothing is left or duplicated
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
        chk("drained vals", int'(s_val), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
